// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl
//   KEY_NUM-channel push-button front end: two-flop synchroniser, per-key
//   debounce counter and an event encoder.  It reports press, release and
//   long-press events as one-cycle pulses, each carrying the key code
//   (index + 1).  At most one event pulse is emitted per cycle.
//
//   Build option: define KEY_REPEAT_EN to make a held key emit a press pulse
//   every REP_CYC cycles once it has reached long-press.  Without the macro
//   the repeat counter is not built and the long-press state stays silent
//   until release.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-low
//   key_in     raw keys, active-low (0 = pressed), asynchronous to clk
//   key_state  debounced level per key, 1 = pressed
//   key_val    event key code (index + 1); 0 when no event pulse
//   key_vld    press (or repeat) event pulse
//   key_rel    release pulse of the active key
//   key_long   long-press pulse of the active key
//
// FSM states
//   state  | meaning
//   S_IDLE | no active key
//   S_HELD | active key held, counting toward long-press
//   S_LONG | long-press reported; silent, or auto-repeating when enabled

module key_scan_ctrl #(
  parameter int KEY_NUM  = 4,
  parameter int CODE_W   = 4,
  parameter int DB_CYC   = 500_000,
  parameter int LONG_CYC = 50_000_000,
  parameter int REP_CYC  = 10_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [CODE_W-1:0]  key_val,
  output logic               key_vld,
  output logic               key_rel,
  output logic               key_long
);

  localparam int DB_W  = (DB_CYC   > 1) ? $clog2(DB_CYC)   : 1;
  localparam int TMR_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
  localparam logic [DB_W-1:0]  DB_TC   = DB_W'(DB_CYC - 1);
  localparam logic [TMR_W-1:0] LONG_TC = TMR_W'(LONG_CYC - 1);
`ifdef KEY_REPEAT_EN
  localparam int REP_W = (REP_CYC > 1) ? $clog2(REP_CYC) : 1;
  localparam logic [REP_W-1:0] REP_TC = REP_W'(REP_CYC - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HELD = 2'd1,
    S_LONG = 2'd2
  } state_t;

  // synchroniser holds raw (active-low) levels; reset value = released
  logic [KEY_NUM-1:0] r_sync1;
  logic [KEY_NUM-1:0] r_sync2;
  logic [KEY_NUM-1:0] w_lvl;
  logic [DB_W-1:0]    r_db_cnt [KEY_NUM];
  logic [KEY_NUM-1:0] r_key_state;
  logic [KEY_NUM-1:0] r_key_state_d;
  logic [KEY_NUM-1:0] w_rise;
  logic [KEY_NUM-1:0] w_fall;
  logic               w_rise_any;
  logic [CODE_W-1:0]  w_rise_code;
  logic               w_act_fall;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TMR_W-1:0]   r_timer;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic [CODE_W-1:0]  r_code;
  logic [CODE_W-1:0]  w_code_nxt;
`ifdef KEY_REPEAT_EN
  logic [REP_W-1:0]   r_rep;
  logic [REP_W-1:0]   w_rep_nxt;
`endif

  logic               r_vld;
  logic               r_rel;
  logic               r_long;
  logic [CODE_W-1:0]  r_val;
  logic               w_vld_nxt;
  logic               w_rel_nxt;
  logic               w_long_nxt;
  logic [CODE_W-1:0]  w_val_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lvl = ~r_sync2;

  // The counter runs only while the synced level disagrees with the
  // debounced level; any agreement restarts the window, so a bounce shorter
  // than DB_CYC cycles never reaches the terminal count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < KEY_NUM; i++) r_db_cnt[i] <= '0;
      r_key_state   <= '0;
      r_key_state_d <= '0;
    end else begin
      for (int i = 0; i < KEY_NUM; i++) begin
        if (w_lvl[i] == r_key_state[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_TC) begin
          r_db_cnt[i]    <= '0;
          r_key_state[i] <= w_lvl[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
      r_key_state_d <= r_key_state;
    end
  end

  assign w_rise = r_key_state & ~r_key_state_d;
  assign w_fall = ~r_key_state & r_key_state_d;

  // descending scan so the lowest-index press edge wins
  always_comb begin
    w_rise_any  = 1'b0;
    w_rise_code = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (w_rise[i]) begin
        w_rise_any  = 1'b1;
        w_rise_code = CODE_W'(i + 1);
      end
    end
  end

  // r_code is 0 in IDLE, so no key can match as active there
  always_comb begin
    w_act_fall = 1'b0;
    for (int i = 0; i < KEY_NUM; i++) begin
      if (w_fall[i] && (r_code == CODE_W'(i + 1))) w_act_fall = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_code  <= '0;
`ifdef KEY_REPEAT_EN
      r_rep   <= '0;
`endif
      r_vld   <= 1'b0;
      r_rel   <= 1'b0;
      r_long  <= 1'b0;
      r_val   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_code  <= w_code_nxt;
`ifdef KEY_REPEAT_EN
      r_rep   <= w_rep_nxt;
`endif
      r_vld   <= w_vld_nxt;
      r_rel   <= w_rel_nxt;
      r_long  <= w_long_nxt;
      r_val   <= w_val_nxt;
    end
  end

  // Branch order gives release > press > long-press when they coincide.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_code_nxt  = r_code;
`ifdef KEY_REPEAT_EN
    w_rep_nxt   = r_rep;
`endif
    w_vld_nxt   = 1'b0;
    w_rel_nxt   = 1'b0;
    w_long_nxt  = 1'b0;
    w_val_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_rise_any) begin
          w_state_nxt = S_HELD;
          w_timer_nxt = '0;
          w_code_nxt  = w_rise_code;
          w_vld_nxt   = 1'b1;
          w_val_nxt   = w_rise_code;
        end
      end
      S_HELD, S_LONG: begin
        if (w_act_fall) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
          w_code_nxt  = '0;
          w_rel_nxt   = 1'b1;
          w_val_nxt   = r_code;
        end else if (w_rise_any) begin
          // switch to the newly pressed key; the old one is forgotten
          w_state_nxt = S_HELD;
          w_timer_nxt = '0;
          w_code_nxt  = w_rise_code;
          w_vld_nxt   = 1'b1;
          w_val_nxt   = w_rise_code;
        end else if (r_state == S_HELD) begin
          if (r_timer == LONG_TC) begin
            w_state_nxt = S_LONG;
            w_timer_nxt = '0;
`ifdef KEY_REPEAT_EN
            w_rep_nxt   = '0;
`endif
            w_long_nxt  = 1'b1;
            w_val_nxt   = r_code;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end else begin
`ifdef KEY_REPEAT_EN
          if (r_rep == REP_TC) begin
            w_rep_nxt = '0;
            w_vld_nxt = 1'b1;
            w_val_nxt = r_code;
          end else begin
            w_rep_nxt = r_rep + 1'b1;
          end
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
        w_code_nxt  = '0;
      end
    endcase
  end

  assign key_state = r_key_state;
  assign key_val   = r_val;
  assign key_vld   = r_vld;
  assign key_rel   = r_rel;
  assign key_long  = r_long;

endmodule
